// File: rtl/sram_dual_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_dual_arbiter
// Purpose  : Shares one dual-port SRAM macro between two requesters, M0 and
//            M1. Port 0 is read/write and port 1 is read-only. Writes always
//            go to port 0. Reads are spread over both ports. Write/write
//            contention is settled round-robin. A read that targets the
//            address being written in the same cycle is stalled.
// Ports    : clk, rst                   - clock, sync active-high reset
//            m{0,1}_valid/ready/we/addr/wdata
//                                       - request handshake per master
//            m{0,1}_rvalid/rdata        - fixed-latency (3) read response
//            sram_csb0/web0/addr0/din0  - registered port 0 command
//            sram_dout0                 - port 0 read data
//            sram_csb1/addr1            - registered port 1 command
//            sram_dout1                 - port 1 read data
//            stall_cnt                  - saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module sram_dual_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,

  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,

  output logic [STAT_WIDTH-1:0] stall_cnt
);

  // Port encoding carried in the response tag.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic wr0, wr1, rd0, rd1;

  assign wr0 = m0_valid &  m0_we;
  assign wr1 = m1_valid &  m1_we;
  assign rd0 = m0_valid & ~m0_we;
  assign rd1 = m1_valid & ~m1_we;

  // --------------------------------------------------------------------------
  // Grant / steering logic
  // --------------------------------------------------------------------------
  logic                  rr_q, rr_d;        // 0: M0 wins next write/write tie
  logic                  grant0, grant1;
  logic                  p0_en, p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_din;
  logic                  p1_en;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [1:0]            tag_v;             // read issued, indexed by master
  logic [1:0]            tag_port;          // port used, indexed by master

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    p0_en    = 1'b0;
    p0_we    = 1'b0;
    p0_addr  = m0_addr;
    p0_din   = m0_wdata;
    p1_en    = 1'b0;
    p1_addr  = m1_addr;
    rr_d     = rr_q;
    tag_v    = 2'b00;
    tag_port = 2'b00;

    // Nothing is granted while reset is asserted, so the first handshake
    // lands in the cycle after reset is released.
    if (!rst) begin
      if (wr0 && wr1) begin
        // Write/write contention: the favoured master writes and the
        // pointer moves to the loser so neither master can be starved.
        p0_en = 1'b1;
        p0_we = 1'b1;
        if (!rr_q) begin
          grant0  = 1'b1;
          p0_addr = m0_addr;
          p0_din  = m0_wdata;
          rr_d    = 1'b1;
        end else begin
          grant1  = 1'b1;
          p0_addr = m1_addr;
          p0_din  = m1_wdata;
          rr_d    = 1'b0;
        end
      end else if (wr0) begin
        grant0  = 1'b1;
        p0_en   = 1'b1;
        p0_we   = 1'b1;
        p0_addr = m0_addr;
        p0_din  = m0_wdata;
        // The macro gives no defined result for a read of the address being
        // written on the same edge, so such a read waits one cycle.
        if (rd1 && (m1_addr != m0_addr)) begin
          grant1      = 1'b1;
          p1_en       = 1'b1;
          p1_addr     = m1_addr;
          tag_v[1]    = 1'b1;
          tag_port[1] = PORT1;
        end
      end else if (wr1) begin
        grant1  = 1'b1;
        p0_en   = 1'b1;
        p0_we   = 1'b1;
        p0_addr = m1_addr;
        p0_din  = m1_wdata;
        if (rd0 && (m0_addr != m1_addr)) begin
          grant0      = 1'b1;
          p1_en       = 1'b1;
          p1_addr     = m0_addr;
          tag_v[0]    = 1'b1;
          tag_port[0] = PORT1;
        end
      end else begin
        // No write this cycle: each master owns one port, so both reads
        // can be granted together.
        if (rd0) begin
          grant0      = 1'b1;
          p0_en       = 1'b1;
          p0_addr     = m0_addr;
          tag_v[0]    = 1'b1;
          tag_port[0] = PORT0;
        end
        if (rd1) begin
          grant1      = 1'b1;
          p1_en       = 1'b1;
          p1_addr     = m1_addr;
          tag_v[1]    = 1'b1;
          tag_port[1] = PORT1;
        end
      end
    end
  end

  assign m0_ready = grant0;
  assign m1_ready = grant1;

  // --------------------------------------------------------------------------
  // Registered SRAM command
  // --------------------------------------------------------------------------
  logic                  csb0_q, web0_q, csb1_q;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] din0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csb0_q  <= 1'b1;
      web0_q  <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
      csb1_q  <= 1'b1;
      addr1_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      csb0_q <= ~p0_en;
      web0_q <= ~p0_we;
      csb1_q <= ~p1_en;
      rr_q   <= rr_d;
      // Address/data only move when the port is used, keeping idle cycles
      // free of toggling on the macro pins.
      if (p0_en) begin
        addr0_q <= p0_addr;
      end
      if (p0_we) begin
        din0_q <= p0_din;
      end
      if (p1_en) begin
        addr1_q <= p1_addr;
      end
    end
  end

  assign sram_csb0  = csb0_q;
  assign sram_web0  = web0_q;
  assign sram_addr0 = addr0_q;
  assign sram_din0  = din0_q;
  assign sram_csb1  = csb1_q;
  assign sram_addr1 = addr1_q;

  // --------------------------------------------------------------------------
  // Response pipeline, one lane per master.
  //   accept N -> s0 tag in N+1 (command on pins)
  //            -> s1 tag in N+2 (macro output valid)
  //            -> rvalid/rdata registered for N+3
  // Each master issues at most one read per cycle, so a lane only needs to
  // remember which port carries its data.
  // --------------------------------------------------------------------------
  for (genvar m = 0; m < 2; m++) begin : g_resp
    logic                  s0_v_q, s0_port_q;
    logic                  s1_v_q, s1_port_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s0_v_q    <= 1'b0;
        s0_port_q <= PORT0;
        s1_v_q    <= 1'b0;
        s1_port_q <= PORT0;
        rvalid_q  <= 1'b0;
        rdata_q   <= '0;
      end else begin
        s0_v_q    <= tag_v[m];
        s0_port_q <= tag_port[m];
        s1_v_q    <= s0_v_q;
        s1_port_q <= s0_port_q;
        rvalid_q  <= s1_v_q;
        // rdata keeps its last value between responses.
        if (s1_v_q) begin
          rdata_q <= (s1_port_q == PORT1) ? sram_dout1 : sram_dout0;
        end
      end
    end
  end

  assign m0_rvalid = g_resp[0].rvalid_q;
  assign m0_rdata  = g_resp[0].rdata_q;
  assign m1_rvalid = g_resp[1].rvalid_q;
  assign m1_rdata  = g_resp[1].rdata_q;

  // --------------------------------------------------------------------------
  // Stall statistics
  // --------------------------------------------------------------------------
  logic                  stall;
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  assign stall = (m0_valid & ~grant0) | (m1_valid & ~grant1);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {STAT_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_dual_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_dual_arbiter
// Purpose  : Directed bench for sram_dual_arbiter with a behavioural SRAM
//            macro and a response scoreboard keyed by master and due cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_dual_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  sram_dual_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
    .stall_cnt(stall_cnt)
  );

  // --------------------------------------------------------------------------
  // Behavioural macro: command captured on posedge, read data after the edge.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem [16];
  logic          mem_init_done = 1'b0;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else begin
      if (!sram_csb0) begin
        if (!sram_web0) mem[sram_addr0] <= sram_din0;
        else            sram_dout0      <= mem[sram_addr0];
      end
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  typedef struct {
    int            m;
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [16];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1);
    m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Sample point of the current cycle: retire due responses, then record
  // this cycle's handshakes (reads before writes, so a write never leaks
  // into another read accepted in the same cycle).
  task automatic at_neg();
    logic          rv;
    logic [DW-1:0] rd;
    int            idx;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      rv  = (m == 0) ? m0_rvalid : m1_rvalid;
      rd  = (m == 0) ? m0_rdata  : m1_rdata;
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].m == m && sb[i].due == cyc) idx = i;
      if (idx >= 0) begin
        chk($sformatf("m%0d_rvalid c%0d", m, cyc), {31'b0, rv}, 32'd1);
        chk($sformatf("m%0d_rdata c%0d", m, cyc), rd, sb[idx].data);
        sb.delete(idx);
      end else begin
        chk($sformatf("m%0d_rvalid_idle c%0d", m, cyc), {31'b0, rv}, 32'd0);
      end
    end
    if (rst) begin
      // Reset drops everything still in flight at the next edge.
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due > cyc) sb.delete(i);
    end else begin
      if (m0_valid && m0_ready && !m0_we) sb.push_back('{0, cyc + 3, shadow[m0_addr]});
      if (m1_valid && m1_ready && !m1_we) sb.push_back('{1, cyc + 3, shadow[m1_addr]});
      if (m0_valid && m0_ready &&  m0_we) shadow[m0_addr] = m0_wdata;
      if (m1_valid && m1_ready &&  m1_we) shadow[m1_addr] = m1_wdata;
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd3, 32'h3333_3333, 1'b1, 1'b0, 4'd4, '0);
    @(posedge clk);
    #1;

    // C0-C1: reset held with both masters requesting.
    at_neg();
    chk("rst_csb0", {31'b0, sram_csb0}, 32'd1);
    chk("rst_csb1", {31'b0, sram_csb1}, 32'd1);
    chk("rst_ready0", {31'b0, m0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, m1_ready}, 32'd0);
    chk("rst_stall", {24'b0, stall_cnt}, 32'd0);
    next();
    at_neg();
    chk("rst_stall2", {24'b0, stall_cnt}, 32'd0);
    chk("rst_web0", {31'b0, sram_web0}, 32'd1);
    next();

    // C2: first grants after release (write 3 + read 4 on port 1).
    rst = 1'b0;
    at_neg();
    chk("rel_ready0", {31'b0, m0_ready}, 32'd1);
    chk("rel_ready1", {31'b0, m1_ready}, 32'd1);
    chk("rel_stall", {24'b0, stall_cnt}, 32'd0);
    next();

    // C3: M0 writes DEADBEEF to 5; C2 command now on the pins.
    drive(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
    at_neg();
    chk("wr5_ready0", {31'b0, m0_ready}, 32'd1);
    chk("cmd_csb0", {31'b0, sram_csb0}, 32'd0);
    chk("cmd_web0", {31'b0, sram_web0}, 32'd0);
    chk("cmd_addr0", {28'b0, sram_addr0}, 32'd3);
    chk("cmd_din0", sram_din0, 32'h3333_3333);
    chk("cmd_csb1", {31'b0, sram_csb1}, 32'd0);
    chk("cmd_addr1", {28'b0, sram_addr1}, 32'd4);
    next();

    // C4: M0 reads 5 right after the write.
    drive(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0);
    at_neg();
    chk("rd5_ready0", {31'b0, m0_ready}, 32'd1);
    next();

    idle();
    at_neg();
    chk("rd_web0", {31'b0, sram_web0}, 32'd1);
    chk("rd_csb0", {31'b0, sram_csb0}, 32'd0);
    next();
    at_neg();
    chk("idle_csb0", {31'b0, sram_csb0}, 32'd1);
    chk("idle_csb1", {31'b0, sram_csb1}, 32'd1);
    next();
    at_neg();                                   // C7: DEADBEEF due
    next();
    at_neg();                                   // C8: rdata holds
    chk("hold_rvalid0", {31'b0, m0_rvalid}, 32'd0);
    chk("hold_rdata0", m0_rdata, 32'hDEAD_BEEF);
    next();

    // Dual read: preload 2 and 9, then read both in one cycle.
    drive(1'b1, 1'b1, 4'd2, 32'h1111_1111, 1'b0, 1'b0, '0, '0);
    at_neg(); next();
    drive(1'b1, 1'b1, 4'd9, 32'h2222_2222, 1'b0, 1'b0, '0, '0);
    at_neg(); next();
    drive(1'b1, 1'b0, 4'd2, '0, 1'b1, 1'b0, 4'd9, '0);
    at_neg();
    chk("dual_ready0", {31'b0, m0_ready}, 32'd1);
    chk("dual_ready1", {31'b0, m1_ready}, 32'd1);
    next();
    idle();
    at_neg(); next();
    at_neg(); next();
    at_neg();                                   // C14: both responses due
    chk("dual_rdata0", m0_rdata, 32'h1111_1111);
    chk("dual_rdata1", m1_rdata, 32'h2222_2222);
    next();

    // Collision: write 7 while M1 reads 7.
    drive(1'b1, 1'b1, 4'd7, 32'h7777_7777, 1'b1, 1'b0, 4'd7, '0);
    at_neg();
    chk("coll_ready0", {31'b0, m0_ready}, 32'd1);
    chk("coll_ready1", {31'b0, m1_ready}, 32'd0);
    chk("coll_stall0", {24'b0, stall_cnt}, 32'd0);
    next();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd7, '0);
    at_neg();
    chk("coll_retry1", {31'b0, m1_ready}, 32'd1);
    chk("coll_stall1", {24'b0, stall_cnt}, 32'd1);
    next();
    // Different address: no stall, old contents of 8.
    drive(1'b1, 1'b1, 4'd7, 32'h7A7A_7A7A, 1'b1, 1'b0, 4'd8, '0);
    at_neg();
    chk("nocoll_ready0", {31'b0, m0_ready}, 32'd1);
    chk("nocoll_ready1", {31'b0, m1_ready}, 32'd1);
    next();

    // Write contention, valid held for three cycles: M0, M1, M0.
    drive(1'b1, 1'b1, 4'd10, 32'hA0A0_A0A0, 1'b1, 1'b1, 4'd11, 32'hB1B1_B1B1);
    at_neg();
    chk("ww0_ready0", {31'b0, m0_ready}, 32'd1);
    chk("ww0_ready1", {31'b0, m1_ready}, 32'd0);
    chk("ww0_stall", {24'b0, stall_cnt}, 32'd1);
    next();
    at_neg();
    chk("ww1_ready0", {31'b0, m0_ready}, 32'd0);
    chk("ww1_ready1", {31'b0, m1_ready}, 32'd1);
    chk("ww1_stall", {24'b0, stall_cnt}, 32'd2);
    next();
    at_neg();
    chk("ww2_ready0", {31'b0, m0_ready}, 32'd1);
    chk("ww2_ready1", {31'b0, m1_ready}, 32'd0);
    chk("ww2_stall", {24'b0, stall_cnt}, 32'd3);
    next();
    idle();
    at_neg();
    chk("ww_stall_end", {24'b0, stall_cnt}, 32'd4);
    next();
    drive(1'b1, 1'b0, 4'd10, '0, 1'b1, 1'b0, 4'd11, '0);
    at_neg(); next();
    idle();
    at_neg(); next();
    at_neg(); next();
    at_neg(); next();                           // C25: contention data due

    // Reset mid-flight: read at N, reset during N+1.
    drive(1'b1, 1'b0, 4'd5, '0, 1'b0, 1'b0, '0, '0);
    at_neg();
    chk("mid_ready0", {31'b0, m0_ready}, 32'd1);
    next();
    idle();
    rst = 1'b1;
    at_neg(); next();
    rst = 1'b0;
    // Pointer was left favouring M1; after reset M0 must win again.
    drive(1'b1, 1'b1, 4'd12, 32'hC0C0_C0C0, 1'b1, 1'b1, 4'd13, 32'hD1D1_D1D1);
    at_neg();
    chk("post_rr_ready0", {31'b0, m0_ready}, 32'd1);
    chk("post_rr_ready1", {31'b0, m1_ready}, 32'd0);
    chk("post_stall", {24'b0, stall_cnt}, 32'd0);
    next();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd13, 32'hD1D1_D1D1);
    at_neg();                                   // N+3 of the dropped read
    chk("mid_no_rvalid0", {31'b0, m0_rvalid}, 32'd0);
    chk("post_ready1", {31'b0, m1_ready}, 32'd1);
    chk("post_stall1", {24'b0, stall_cnt}, 32'd1);
    next();
    drive(1'b1, 1'b0, 4'd12, '0, 1'b1, 1'b0, 4'd13, '0);
    at_neg(); next();
    idle();
    for (int k = 0; k < 4; k++) begin
      at_neg(); next();
    end

    chk("sb_drained", sb.size(), 32'd0);
    chk("final_stall", {24'b0, stall_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_dual_arbiter.md
Name: sram_dual_arbiter

Overview:
- Shares one 16x32 dual-port SRAM macro (port 0 read/write, port 1 read-only) between two requesters, M0 and M1.
- Each requester uses a valid/ready request handshake and a fixed-latency response.
- Writes are steered to port 0 and reads are spread across both ports. Same-address write/read collisions and write/write contention are resolved by stalling.
- Sits between the user-logic masters and the SRAM macro. The macro clocks (clk0/clk1) are tied to clk at the top level.

Parameters:
- ADDR_WIDTH, 4, SRAM address width.
- DATA_WIDTH, 32, SRAM word width.
- STAT_WIDTH, 8, width of the saturating stall counter.

Ports:
- clk  in  1  Single clock; also drives both SRAM port clocks.
- rst  in  1  Synchronous, active-high reset.
- m0_valid  in  1  M0 request valid.
- m0_ready  out  1  M0 request accepted this cycle (combinational).
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  ADDR_WIDTH  M0 address.
- m0_wdata  in  DATA_WIDTH  M0 write data.
- m0_rvalid  out  1  M0 read data valid (one-cycle pulse).
- m0_rdata  out  DATA_WIDTH  M0 read data.
- m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_rvalid, m1_rdata: same as the M0 ports, for M1.
- sram_csb0  out  1  Port 0 chip select, active low, registered.
- sram_web0  out  1  Port 0 write enable, active low, registered.
- sram_addr0  out  ADDR_WIDTH  Port 0 address, registered.
- sram_din0  out  DATA_WIDTH  Port 0 write data, registered.
- sram_dout0  in  DATA_WIDTH  Port 0 read data.
- sram_csb1  out  1  Port 1 chip select, active low, registered.
- sram_addr1  out  ADDR_WIDTH  Port 1 address, registered.
- sram_dout1  in  DATA_WIDTH  Port 1 read data.
- stall_cnt  out  STAT_WIDTH  Saturating count of cycles in which any valid request had ready=0.

Behaviour:
- Reset values:
  - sram_csb0=1, sram_web0=1, sram_csb1=1; addr/din = 0.
  - m*_rvalid=0, m*_rdata=0, stall_cnt=0.
  - Round-robin pointer rr=0 (M0 favoured).
  - Response pipeline cleared, so in-flight reads are dropped and no rvalid follows reset.
- Grant rules are evaluated each cycle from the current inputs:
  - Both write: the master named by rr gets port 0 and the other is stalled. After the grant, rr points to the loser.
  - One write: the writer gets port 0. The other master's read (if valid) goes to port 1, unless its addr equals the write addr; then it is stalled.
  - No write: an M0 read uses port 0 and an M1 read uses port 1. Both are granted in the same cycle.
  - A lone write does not change rr; only a write/write conflict updates it.
- m*_ready = grant. A handshake is valid&ready.
- The SRAM command is registered at the posedge ending the accept cycle N. The SRAM captures it at the posedge ending N+1.
- A port with no grant drives csb=1 next cycle. web0=0 only for a granted write.
- Read latency is fixed at 3: accepted in cycle N gives m*_rvalid=1 in cycle N+3.
  - m*_rdata = sram_dout0 or sram_dout1 sampled at the posedge ending N+2.
  - Port selection follows a 3-deep tag pipeline of {valid, master, port}.
  - There is no response backpressure.
- m*_rdata holds its last value when rvalid=0.
- Writes produce no response.
- A read accepted the cycle after a write to the same address returns the new data; no stall is needed.
- Up to two reads can complete in the same cycle, one per master.
- stall_cnt increments by 1 per cycle with at least one (valid & !ready) and saturates at all-ones.

Test Plan:
- Reset: assert rst for 2 cycles with m0/m1 valid high → csb0=csb1=1, no rvalid, stall_cnt=0; first grants occur in the cycle after rst drops.
- Write then read: M0 writes 0xDEADBEEF to addr 5, then M0 reads addr 5 the next cycle → m0_rvalid exactly 3 cycles after the read accept, m0_rdata=0xDEADBEEF.
- Dual read: preload addr 2=0x11111111 and addr 9=0x22222222; M0 reads 2 and M1 reads 9 in the same cycle → both ready; 3 cycles later both rvalid, m0_rdata=0x11111111, m1_rdata=0x22222222.
- Collision: M0 writes addr 7 while M1 reads addr 7 → m1_ready=0 and stall_cnt goes 0→1; M1 is granted the next cycle and returns the new data. Repeat with M1 reading addr 8 → no stall, old data returned.
- Write contention: both write different addrs with valid held → alternating grants M0, M1, M0; no master starved; stall counted each cycle.
- Reset mid-flight: accept a read, assert rst at N+1 → no rvalid at N+3; stall_cnt=0 and rr=0 after release.
